fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one-outstanding-request fetch engine with a single
// skid entry for responses that arrive while decode is stalled, feeding IF/ID.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } fetchState_t;

   fetchState_t stateReg;
   fetchState_t stateNext;

   logic [31:0] pcfReg;
   logic [31:0] pendingPcReg;
   logic [31:0] bufInstrReg;
   logic [31:0] bufPcReg;
   logic        bufValidReg;

   logic [31:0] instrDReg;
   logic [31:0] pcDReg;
   logic [31:0] pcPlus4DReg;
   logic        validDReg;

   logic [31:0] redirectTarget;
   logic        acceptGnt;
   logic        deliverResp;
   logic        deliverBuf;
   logic        captureBuf;
   logic        releaseBuf;

   assign redirectTarget = {RedirectPC[31:2], 2'b00};

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateReg <= S_REQ;
      end else begin
         stateReg <= stateNext;
      end
   end

   // Next-state logic; Redirect outranks every other event in every state
   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         S_REQ: begin
            if (Redirect) begin
               stateNext = imem_gnt ? S_DROP : S_REQ;
            end else if (imem_gnt) begin
               stateNext = S_WAIT;
            end
         end
         S_WAIT: begin
            if (Redirect) begin
               stateNext = imem_rvalid ? S_REQ : S_DROP;
            end else if (imem_rvalid) begin
               stateNext = StallD ? S_HOLD : S_REQ;
            end
         end
         S_HOLD: begin
            if (Redirect || !StallD) begin
               stateNext = S_REQ;
            end
         end
         S_DROP: begin
            // The stale response still has to drain before a new request can go out
            if (imem_rvalid) begin
               stateNext = S_REQ;
            end
         end
         default: stateNext = S_REQ;
      endcase
   end

   // Output / control decode
   always_comb begin
      imem_req    = 1'b0;
      acceptGnt   = 1'b0;
      deliverResp = 1'b0;
      deliverBuf  = 1'b0;
      captureBuf  = 1'b0;
      releaseBuf  = 1'b0;
      case (stateReg)
         S_REQ: begin
            imem_req  = rst;
            acceptGnt = imem_gnt && !Redirect;
         end
         S_WAIT: begin
            deliverResp = imem_rvalid && !Redirect && !StallD;
            captureBuf  = imem_rvalid && !Redirect && StallD;
         end
         S_HOLD: begin
            deliverBuf = !Redirect && !StallD;
            releaseBuf = Redirect || !StallD;
         end
         default: begin
         end
      endcase
   end

   assign imem_addr = pcfReg;

   // Fetch PC and pending-request PC
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcfReg       <= RESET_PC;
         pendingPcReg <= 32'h0000_0000;
      end else begin
         if (Redirect) begin
            pcfReg <= redirectTarget;
         end else if (acceptGnt) begin
            pcfReg <= pcfReg + 32'd4;
         end
         if (acceptGnt) begin
            pendingPcReg <= pcfReg;
         end
      end
   end

   // One-entry skid buffer for a response that lands while decode is stalled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bufInstrReg <= 32'h0000_0000;
         bufPcReg    <= 32'h0000_0000;
         bufValidReg <= 1'b0;
      end else begin
         if (captureBuf) begin
            bufInstrReg <= imem_rdata;
            bufPcReg    <= pendingPcReg;
            bufValidReg <= 1'b1;
         end else if (releaseBuf) begin
            bufValidReg <= 1'b0;
         end
      end
   end

   // IF/ID register: flush beats stall beats load beats bubble
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instrDReg   <= NOP_INSTR;
         pcDReg      <= 32'h0000_0000;
         pcPlus4DReg <= 32'h0000_0000;
         validDReg   <= 1'b0;
      end else if (FlushD) begin
         instrDReg <= NOP_INSTR;
         validDReg <= 1'b0;
      end else if (StallD) begin
         instrDReg   <= instrDReg;
         pcDReg      <= pcDReg;
         pcPlus4DReg <= pcPlus4DReg;
         validDReg   <= validDReg;
      end else if (deliverResp) begin
         instrDReg   <= imem_rdata;
         pcDReg      <= pendingPcReg;
         pcPlus4DReg <= pendingPcReg + 32'd4;
         validDReg   <= 1'b1;
      end else if (deliverBuf && bufValidReg) begin
         instrDReg   <= bufInstrReg;
         pcDReg      <= bufPcReg;
         pcPlus4DReg <= bufPcReg + 32'd4;
         validDReg   <= 1'b1;
      end else begin
         instrDReg <= NOP_INSTR;
         validDReg <= 1'b0;
      end
   end

   assign InstrD   = instrDReg;
   assign PCD      = pcDReg;
   assign PCPlus4D = pcPlus4DReg;
   assign ValidD   = validDReg;

endmodule
